// File: rtl/alu_pkg.sv
// Shared ALU encodings: mode bit and logic-extender function selects.
package alu_pkg;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    localparam logic [1:0] LE_NOT = 2'b00;
    localparam logic [1:0] LE_AND = 2'b01;
    localparam logic [1:0] LE_ID  = 2'b10;
    localparam logic [1:0] LE_OR  = 2'b11;

endpackage

// File: rtl/logic_extender_if.sv
// Operand/select bundle between the ALU control and the logic extender.
interface logic_extender_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             s0;
    logic             s1;
    logic             m;
    logic [WIDTH-1:0] x_i;

    modport master (
        output a_i,
        output b_i,
        output s0,
        output s1,
        output m,
        input  x_i
    );

    modport slave (
        input  a_i,
        input  b_i,
        input  s0,
        input  s1,
        input  m,
        output x_i
    );
endinterface

// File: rtl/logic_extender_slice.sv
// One combinational bit-slice of the logic extender.
module logic_extender_slice
    import alu_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic s1_i,
    input  logic s0_i,
    input  logic m_i,
    output logic f_o
);

    // Decode all eight {m,s1,s0} codes; anything else (X/Z) yields X.
    always_comb begin
        f_o = 1'bx;
        case ({m_i, s1_i, s0_i})
            {MODE_ARITH, LE_NOT}: f_o = a_i;
            {MODE_ARITH, LE_AND}: f_o = a_i;
            {MODE_ARITH, LE_ID}:  f_o = a_i;
            {MODE_ARITH, LE_OR}:  f_o = a_i;
            {MODE_LOGIC, LE_NOT}: f_o = ~a_i;
            {MODE_LOGIC, LE_AND}: f_o = a_i & b_i;
            {MODE_LOGIC, LE_ID}:  f_o = a_i;
            {MODE_LOGIC, LE_OR}:  f_o = a_i | b_i;
            default:              f_o = 1'bx;
        endcase
    end

endmodule

// File: rtl/logic_extender.sv
// WIDTH independent logic-extender slices feeding one output register.
module logic_extender
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    logic_extender_if.slave  bus
);

    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] x_q;

    for (genvar k = 0; k < WIDTH; k++) begin : g_slice
        logic_extender_slice u_slice (
            .a_i  (bus.a_i[k]),
            .b_i  (bus.b_i[k]),
            .s1_i (bus.s1),
            .s0_i (bus.s0),
            .m_i  (bus.m),
            .f_o  (x_d[k])
        );
    end

    // Output register: loads every edge, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

    assign bus.x_i = x_q;

endmodule

// File: tb/tb_logic_extender.sv
// Self-checking bench for logic_extender at WIDTH 1, 8 and 16.
module tb_logic_extender;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic_extender_if #(.WIDTH(1))  if1  ();
    logic_extender_if #(.WIDTH(8))  if8  ();
    logic_extender_if #(.WIDTH(16)) if16 ();

    logic_extender #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    logic_extender #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    logic_extender #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level reference of the extender function, straight from the function table.
    function automatic logic [63:0] ref_f(input logic m, input logic [1:0] sel,
                                          input logic [63:0] a, input logic [63:0] b);
        if (!m) return a;
        case (sel)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a;
            default: return a | b;
        endcase
    endfunction

    task automatic drive8(input logic m, input logic [1:0] sel, input logic [7:0] a,
                          input logic [7:0] b);
        if8.m   = m;
        if8.s1  = sel[1];
        if8.s0  = sel[0];
        if8.a_i = a;
        if8.b_i = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_tests++;
        if (if1.x_i !== 1'b0 || if8.x_i !== 8'h00 || if16.x_i !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset: x1=%b x8=%h x16=%h required 0", if1.x_i, if8.x_i, if16.x_i);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [4:0] v;
        logic [63:0] e;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            v = i[4:0];
            if1.m   = v[4];
            if1.s1  = v[3];
            if1.s0  = v[2];
            if1.a_i = v[1];
            if1.b_i = v[0];
            e = ref_f(v[4], v[3:2], {63'd0, v[1]}, {63'd0, v[0]});
            @(posedge clk);
            #1;
            n_tests++;
            if (if1.x_i !== e[0]) begin
                n_fail++;
                $display("FAIL exhaustive %05b: x=%b required %b", v, if1.x_i, e[0]);
            end
        end
    endtask

    task automatic test_arith();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            drive8(1'b0, s[1:0], 8'hA5, 8'h3C);
            @(posedge clk);
            #1;
            n_tests++;
            if (if8.x_i !== 8'hA5) begin
                n_fail++;
                $display("FAIL arith sel=%0d: x=%h required a5", s, if8.x_i);
            end
        end
    endtask

    task automatic test_logic();
        logic [7:0] exp_tab [4];
        exp_tab[0] = 8'h5A;
        exp_tab[1] = 8'h24;
        exp_tab[2] = 8'hA5;
        exp_tab[3] = 8'hBD;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            drive8(1'b1, s[1:0], 8'hA5, 8'h3C);
            @(posedge clk);
            #1;
            n_tests++;
            if (if8.x_i !== exp_tab[s]) begin
                n_fail++;
                $display("FAIL logic sel=%0d: x=%h required %h", s, if8.x_i, exp_tab[s]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        drive8(1'b1, 2'b00, 8'hA5, 8'h3C);
        @(posedge clk);
        #1;
        n_tests++;
        if (if8.x_i !== 8'h5A) begin
            n_fail++;
            $display("FAIL latency_not: x=%h required 5a", if8.x_i);
        end
        drive8(1'b1, 2'b11, 8'hA5, 8'h3C);
        @(negedge clk);
        n_tests++;
        if (if8.x_i !== 8'h5A) begin
            n_fail++;
            $display("FAIL latency_hold: x=%h required 5a", if8.x_i);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (if8.x_i !== 8'hBD) begin
            n_fail++;
            $display("FAIL latency_or: x=%h required bd", if8.x_i);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        n_tests++;
        if (if8.x_i !== 8'hBD) begin
            n_fail++;
            $display("FAIL areset_pre: x=%h required bd", if8.x_i);
        end
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (if8.x_i !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_immediate: x=%h required 00", if8.x_i);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (if8.x_i !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_hold: x=%h required 00", if8.x_i);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (if8.x_i !== 8'hBD) begin
            n_fail++;
            $display("FAIL areset_release: x=%h required bd", if8.x_i);
        end
    endtask

    task automatic test_back_to_back();
        logic        m;
        logic [1:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [63:0] e;
        int          errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            m   = 1'($urandom);
            sel = 2'($urandom);
            a   = 16'($urandom);
            b   = 16'($urandom);
            if16.m   = m;
            if16.s1  = sel[1];
            if16.s0  = sel[0];
            if16.a_i = a;
            if16.b_i = b;
            e = ref_f(m, sel, {48'd0, a}, {48'd0, b});
            @(posedge clk);
            #1;
            n_tests++;
            if (if16.x_i !== e[15:0]) begin
                n_fail++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL random #%0d m=%b sel=%0d a=%h b=%h: x=%h required %h",
                             i, m, sel, a, b, if16.x_i, e[15:0]);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        if1.m = 1'b0;  if1.s1 = 1'b0;  if1.s0 = 1'b0;  if1.a_i = '0;  if1.b_i = '0;
        if8.m = 1'b0;  if8.s1 = 1'b0;  if8.s0 = 1'b0;  if8.a_i = '0;  if8.b_i = '0;
        if16.m = 1'b0; if16.s1 = 1'b0; if16.s0 = 1'b0; if16.a_i = '0; if16.b_i = '0;

        test_reset();
        test_exhaustive();
        test_arith();
        test_logic();
        test_latency();
        test_async_reset();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_extender.md
Name: logic_extender

Overview:
- Bit-slice logic extender (LE) for the toy processor ALU.
- Produces the operand x_i that feeds the ALU's adder stage.
- In arithmetic mode (m=0) a_i passes through unchanged. In logic mode (m=1) x_i is a bitwise logic function of a_i and b_i, selected by s1/s0.
- Parameterised width; output is registered on one clock with an asynchronous active-high reset.

Parameters:
- WIDTH, 1, number of bit-slices processed in parallel. Legal range is 1 to 64; the default of 1 models a single ALU slice.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_i  input  WIDTH  operand A, bit per slice.
- b_i  input  WIDTH  operand B, bit per slice.
- s0  input  1  function select, low bit.
- s1  input  1  function select, high bit.
- m  input  1  mode: 0 = arithmetic, 1 = logic.
- x_i  output  WIDTH  extended operand, registered.

Behaviour:
- Function per bit k. Every slice is identical and independent, with no carry between slices.
  - m=0, any s1/s0: f[k] = a_i[k] (pass-through for the arithmetic path).
  - m=1, s1s0=00: f[k] = ~a_i[k] (complement).
  - m=1, s1s0=01: f[k] = a_i[k] & b_i[k] (AND).
  - m=1, s1s0=10: f[k] = a_i[k] (identity).
  - m=1, s1s0=11: f[k] = a_i[k] | b_i[k] (OR).
- Register and latency:
  - x_i <= f on every rising edge of clk, with no enable.
  - Latency is exactly 1 cycle from an input change to x_i. Throughput is one new result per cycle.
- Reset:
  - While rst=1, x_i = all zeros immediately, independent of clk.
  - On rst deassertion, the first rising edge loads f.
  - rst asserted mid-operation discards the pending value; there is no recovery of the prior result.
- Unknown inputs:
  - X/Z on m, s1 or s0 must propagate as X on x_i in simulation; do not silently default.
  - Synthesis treats all four s1s0 codes as decoded, so no latch and no default path is needed.
- b_i is don't-care when m=0, and also for s1s0=00 and s1s0=10.
- No internal state other than the x_i register.

Decomposition:
- Shared package alu_pkg:
  - mode constants MODE_ARITH=1'b0 and MODE_LOGIC=1'b1;
  - 2-bit select constants LE_NOT=2'b00, LE_AND=2'b01, LE_ID=2'b10, LE_OR=2'b11.
- Natural sub-module: logic_extender_slice, a purely combinational 1-bit function of (a, b, s1, s0, m) producing f.
  - Instantiate it WIDTH times with a generate loop.
  - The parent logic_extender holds only the output register and reset.

Test Plan:
- Exhaustive, WIDTH=1: apply all 32 combinations of {m,s1,s0,a_i,b_i} = 0..31, one per cycle, and check x_i one cycle later.
  - Example: {1,0,1,1,1} gives x_i=1.
  - Example: {1,0,0,1,0} gives x_i=0.
  - Example: {0,1,1,0,1} gives x_i=0.
- Arithmetic pass, WIDTH=8: m=0, s1s0 cycling 00..11, a_i=8'hA5, b_i=8'h3C -> x_i=8'hA5 for every select.
- Logic ops, WIDTH=8, a_i=8'hA5, b_i=8'h3C, m=1:
  - s1s0=00 -> 8'h5A;
  - 01 -> 8'h24;
  - 10 -> 8'hA5;
  - 11 -> 8'hBD.
- Latency: change the inputs from the NOT case to the OR case at a clock edge. x_i holds 8'h5A until the next rising edge, then shows 8'hBD.
- Async reset: assert rst between clock edges while x_i=8'hBD.
  - x_i must read 8'h00 before the next edge and stay 8'h00 while rst=1.
  - After deassertion, the first edge loads f.
- Back-to-back random: 1000 cycles of random m/s1/s0/a_i/b_i with WIDTH=16, compared against a reference model delayed by one cycle; zero mismatches required.
